// File: rtl/cpu_pkg.sv
// Shared types and constants for the single-clock RISC CPU pipeline.
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // IF/ID pipeline register contents handed to decode.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } if_id_t;

    // Force a byte address onto a word boundary (misaligned targets are silently fixed).
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bus bundle between the fetch stage, instruction memory, hazard/execute control and decode.
interface fetch_stage_if
    import cpu_pkg::*;
();

    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_instr;
    logic [XLEN-1:0] if_id_instr;
    logic [XLEN-1:0] if_id_pc;
    logic [XLEN-1:0] if_id_pc4;
    logic            if_id_valid;
    logic [31:0]     fetch_count;

    // Fetch stage side.
    modport master (
        input  stall, redirect, redirect_pc, imem_instr,
        output imem_addr, if_id_instr, if_id_pc, if_id_pc4, if_id_valid, fetch_count
    );

    // Environment side: memory, hazard unit, execute redirect and decode.
    modport slave (
        output stall, redirect, redirect_pc, imem_instr,
        input  imem_addr, if_id_instr, if_id_pc, if_id_pc4, if_id_valid, fetch_count
    );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: reset > squash > load > hold.
// A squash turns the slot into a bubble (NOP, invalid) but leaves pc/pc4 untouched.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   squash,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t q_r;

    // Pipeline register update with synchronous reset and bubble insertion.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r.instr <= NOP_INSTR;
            q_r.pc    <= {XLEN{1'b0}};
            q_r.pc4   <= {XLEN{1'b0}};
            q_r.valid <= 1'b0;
        end else if (squash) begin
            q_r.instr <= NOP_INSTR;
            q_r.valid <= 1'b0;
        end else if (load) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and retired-fetch counter.
// The PC drives the instruction memory directly; the returned word is captured in if_id_reg.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
)(
    input logic          clk,
    input logic          rst,
    fetch_stage_if.master bus
);

    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_next_s;
    logic [XLEN-1:0] pc_plus4_s;
    logic [31:0]     count_r;
    logic            load_s;
    logic            squash_s;
    if_id_t          if_id_d_s;
    if_id_t          if_id_q_s;

    assign pc_plus4_s = pc_r + 32'd4;

    // Next-PC selection: redirect overrides stall; otherwise advance sequentially.
    always_comb begin
        pc_next_s = pc_r;
        load_s    = 1'b0;
        squash_s  = 1'b0;
        if (bus.redirect) begin
            pc_next_s = align_word(bus.redirect_pc);
            squash_s  = 1'b1;
        end else if (bus.stall) begin
            pc_next_s = pc_r;
        end else begin
            pc_next_s = pc_plus4_s;
            load_s    = 1'b1;
        end
    end

    // Candidate IF/ID contents for a normal fetch.
    always_comb begin
        if_id_d_s.instr = bus.imem_instr;
        if_id_d_s.pc    = pc_r;
        if_id_d_s.pc4   = pc_plus4_s;
        if_id_d_s.valid = 1'b1;
    end

    // Program counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    // Count instructions loaded into IF/ID as valid; wraps silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 32'd0;
        end else if (load_s) begin
            count_r <= count_r + 32'd1;
        end else begin
            count_r <= count_r;
        end
    end

    if_id_reg u_if_id_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (load_s),
        .squash (squash_s),
        .d      (if_id_d_s),
        .q      (if_id_q_s)
    );

    assign bus.imem_addr   = pc_r;
    assign bus.if_id_instr = if_id_q_s.instr;
    assign bus.if_id_pc    = if_id_q_s.pc;
    assign bus.if_id_pc4   = if_id_q_s.pc4;
    assign bus.if_id_valid = if_id_q_s.valid;
    assign bus.fetch_count = count_r;

endmodule
